// File: rtl/buff_uart_tx.sv
// rtl/buff_uart_tx.sv - buffered UART transmitter: byte FIFO feeding an 8N1/8E1 serializer
//
// Queues bytes written with wr_en into a DEPTH-entry FIFO and sends each one
// as a UART frame on tx_serial, LSB first, line idling high. Frames stream
// back to back while the FIFO has data.
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined   -> even parity bit after the data bits (8E1, 11 bit times)
//   undefined -> no parity bit (8N1, 10 bit times)
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per serial bit
//   DEPTH         FIFO entries (power of 2, >= 2)
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous reset, active-high
//   tx_data    in   [7:0] byte to queue
//   wr_en      in   push tx_data this cycle
//   tx_serial  out  registered serial line, idle high
//   full       out  FIFO holds DEPTH entries
//   empty      out  FIFO holds no entries
//   busy       out  serializer not idle
//   tx_done    out  one-cycle pulse on the last cycle of each stop bit
//   err_LED    out  sticky: a push was attempted while full

module buff_uart_tx #(
   parameter int CLKS_PER_BIT = 1250,
   parameter int DEPTH        = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       wr_en,
   output logic       tx_serial,
   output logic       full,
   output logic       empty,
   output logic       busy,
   output logic       tx_done,
   output logic       err_LED
);

   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_W  = $clog2(DEPTH + 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   state_t state, state_nxt;

   logic [7:0]        mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [CNT_W-1:0]  count;
   logic [7:0]        shift_reg;
   logic [BAUD_W-1:0] baud, baud_nxt;
   logic [2:0]        bit_idx, bit_nxt;
   logic              baud_last;
   logic              push, pop;
   logic              line_nxt, done_nxt;

   assign full      = (count == CNT_W'(DEPTH));
   assign empty     = (count == '0);
   assign busy      = (state != IDLE);
   // A push while full is dropped even if the FSM pops in the same cycle.
   assign push      = wr_en && !full;
   assign baud_last = (baud == BAUD_W'(CLKS_PER_BIT - 1));

   always_comb begin
      state_nxt = state;
      baud_nxt  = baud + BAUD_W'(1);
      bit_nxt   = bit_idx;
      pop       = 1'b0;
      line_nxt  = 1'b1;
      done_nxt  = 1'b0;
      case (state)
         IDLE: begin
            baud_nxt = '0;
            if (!empty) begin
               pop       = 1'b1;
               state_nxt = START;
            end
         end
         START: begin
            line_nxt = 1'b0;
            if (baud_last) begin
               baud_nxt  = '0;
               bit_nxt   = 3'd0;
               state_nxt = DATA;
            end
         end
         DATA: begin
            line_nxt = shift_reg[bit_idx];
            if (baud_last) begin
               baud_nxt = '0;
               if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_nxt = PARITY;
`else
                  state_nxt = STOP;
`endif
               end else begin
                  bit_nxt = bit_idx + 3'd1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            line_nxt = ^shift_reg;
            if (baud_last) begin
               baud_nxt  = '0;
               state_nxt = STOP;
            end
         end
`endif
         STOP: begin
            line_nxt = 1'b1;
            if (baud_last) begin
               baud_nxt = '0;
               done_nxt = 1'b1;
               // Chain straight into the next frame when data is waiting.
               if (!empty) begin
                  pop       = 1'b1;
                  state_nxt = START;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: begin
            baud_nxt  = '0;
            state_nxt = IDLE;
         end
      endcase
   end

   // The line and tx_done are registered from the current state, so the
   // line lags the state by one cycle: pop at N+1, falling edge at N+2.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         baud      <= '0;
         bit_idx   <= '0;
         tx_serial <= 1'b1;
         tx_done   <= 1'b0;
         shift_reg <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         err_LED   <= 1'b0;
      end else begin
         state     <= state_nxt;
         baud      <= baud_nxt;
         bit_idx   <= bit_nxt;
         tx_serial <= line_nxt;
         tx_done   <= done_nxt;
         if (pop) begin
            shift_reg <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + PTR_W'(1);
         end
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         if (wr_en && full) begin
            err_LED <= 1'b1;
         end
      end
   end

   // Storage needs no reset; occupancy is tracked by count.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= tx_data;
      end
   end

endmodule

// File: tb/tb_buff_uart_tx.sv
// tb/tb_buff_uart_tx.sv - directed self-checking bench for buff_uart_tx

module tb_buff_uart_tx;

   localparam int CPB   = 16;
   localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int FRAME = NBITS * CPB;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] tx_data;
   logic       wr_en;
   logic       tx_serial, full, empty, busy, tx_done, err_LED;

   buff_uart_tx #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .tx_data   (tx_data),
      .wr_en     (wr_en),
      .tx_serial (tx_serial),
      .full      (full),
      .empty     (empty),
      .busy      (busy),
      .tx_done   (tx_done),
      .err_LED   (err_LED)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Line monitor: detects start bits, samples mid-bit, logs frames and tx_done times.
   logic        mon_active = 1'b0;
   int          mon_cnt = 0;
   logic [10:0] mon_bits = '0;
   logic [10:0] frame_q[$];
   int          fall_q[$];
   int          done_q[$];

   always @(negedge clk) begin
      if (rst) begin
         mon_active = 1'b0;
      end else if (!mon_active) begin
         if (tx_serial === 1'b0) begin
            mon_active = 1'b1;
            mon_cnt    = 0;
            mon_bits   = '0;
            fall_q.push_back(cyc);
         end
      end else begin
         mon_cnt++;
         if (mon_cnt % CPB == CPB / 2) begin
            mon_bits[mon_cnt / CPB] = tx_serial;
            if (mon_cnt / CPB == NBITS - 1) begin
               frame_q.push_back(mon_bits);
               mon_active = 1'b0;
            end
         end
      end
      if (tx_done === 1'b1) done_q.push_back(cyc);
   end

   function automatic logic [10:0] frame_at(input int i);
      return (i < frame_q.size()) ? frame_q[i] : 11'h7FF;
   endfunction
   function automatic int fall_at(input int i);
      return (i < fall_q.size()) ? fall_q[i] : -100000;
   endfunction
   function automatic int done_at(input int i);
      return (i < done_q.size()) ? done_q[i] : -100000;
   endfunction

   // Expected line pattern for one byte: {stop, [parity], data, start}.
   function automatic logic [10:0] frame_of(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
      return {1'b1, ^b, b, 1'b0};
`else
      return {1'b0, 1'b1, b, 1'b0};
`endif
   endfunction

   task automatic push(input logic [7:0] b);
      @(negedge clk);
      tx_data = b;
      wr_en   = 1'b1;
      @(negedge clk);
      wr_en   = 1'b0;
   endtask

   task automatic wait_frames(input string tag, input int target, input int budget);
      int n = 0;
      while (frame_q.size() < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(tag, frame_q.size() >= target, 1);
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n = 0;
      while ((busy || !empty) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(tag, !busy && empty, 1);
      repeat (2) @(negedge clk);
   endtask

   int fb, db, fr;
   logic [7:0] hann [3] = '{8'h48, 8'h41, 8'h4E};
   logic [7:0] six  [6] = '{8'h10, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

   initial begin
      rst = 1'b1; wr_en = 1'b0; tx_data = 8'h00;

      // 1 reset
      repeat (2) @(negedge clk);
      check("rst_tx_serial", tx_serial, 1);
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_busy", busy, 0);
      check("rst_err", err_LED, 0);
      check("rst_tx_done", tx_done, 0);
      rst = 1'b0;

      // 2 single byte 'A', latency and frame timing
      fr = frame_q.size(); fb = fall_q.size(); db = done_q.size();
      push(8'h41);
      check("lat_empty_after_push", empty, 0);
      @(negedge clk);
      check("lat_line_high_n1", tx_serial, 1);
      check("lat_busy_n1", busy, 1);
      check("lat_empty_n1", empty, 1);
      @(negedge clk);
      check("lat_line_low_n2", tx_serial, 0);
      wait_frames("a_frame_wait", fr + 1, 3 * FRAME);
      wait_idle("a_idle", 3 * FRAME);
`ifdef UART_TX_PARITY_EN
      check("a_bits", frame_at(fr), 11'h482);
`else
      check("a_bits", frame_at(fr), 11'h282);
`endif
      check("a_done_count", done_q.size() - db, 1);
      check("a_done_offset", done_at(db) - fall_at(fb), FRAME - 1);

      // 3 back-to-back "HAN"
      fr = frame_q.size(); fb = fall_q.size(); db = done_q.size();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         tx_data = hann[i];
         wr_en   = 1'b1;
      end
      @(negedge clk);
      wr_en = 1'b0;
      for (int n = 0; n < 4 * FRAME && fall_q.size() < fb + 3; n++) @(negedge clk);
      check("han_empty_third", empty, 1);
      check("han_busy_third", busy, 1);
      wait_frames("han_frame_wait", fr + 3, 5 * FRAME);
      wait_idle("han_idle", 3 * FRAME);
      for (int i = 0; i < 3; i++) check("han_bits", frame_at(fr + i), frame_of(hann[i]));
      check("han_gap1", fall_at(fb + 1) - fall_at(fb), FRAME);
      check("han_gap2", fall_at(fb + 2) - fall_at(fb + 1), FRAME);
      check("han_done_count", done_q.size() - db, 3);
      check("han_done_gap1", done_at(db + 1) - done_at(db), FRAME);
      check("han_done_gap2", done_at(db + 2) - done_at(db + 1), FRAME);

      // 4 overflow: six pushes back to back, fifth fills, sixth dropped
      fr = frame_q.size(); db = done_q.size();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i > 0) begin
            check("ovf_full", full, (i - 1) >= 4);
            check("ovf_err", err_LED, (i - 1) >= 5);
         end
         tx_data = six[i];
         wr_en   = 1'b1;
      end
      @(negedge clk);
      wr_en = 1'b0;
      check("ovf_full_last", full, 1);
      check("ovf_err_last", err_LED, 1);
      wait_frames("ovf_frame_wait", fr + 5, 8 * FRAME);
      wait_idle("ovf_idle", 3 * FRAME);
      repeat (2 * FRAME) @(negedge clk);
      check("ovf_frame_count", frame_q.size() - fr, 5);
      check("ovf_done_count", done_q.size() - db, 5);
      for (int i = 0; i < 5; i++) check("ovf_bits", frame_at(fr + i), frame_of(six[i]));
      check("ovf_err_sticky", err_LED, 1);

      // 5 reset in the middle of the data bits of 8'hA5
      fr = frame_q.size(); fb = fall_q.size(); db = done_q.size();
      push(8'hA5);
      for (int n = 0; n < 20 && fall_q.size() <= fb; n++) @(negedge clk);
      check("abort_started", fall_q.size() - fb, 1);
      repeat (CPB + 4 * CPB) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("abort_line", tx_serial, 1);
      check("abort_busy", busy, 0);
      check("abort_empty", empty, 1);
      check("abort_err_clr", err_LED, 0);
      rst = 1'b0;
      repeat (2 * FRAME) @(negedge clk);
      check("abort_no_done", done_q.size() - db, 0);
      check("abort_no_frame", frame_q.size() - fr, 0);

      // 6 bytes 8'h07 and 8'h03: parity bit in the 8E1 build
      fr = frame_q.size(); fb = fall_q.size(); db = done_q.size();
      push(8'h07);
      wait_frames("p07_wait", fr + 1, 3 * FRAME);
      wait_idle("p07_idle", 3 * FRAME);
      push(8'h03);
      wait_frames("p03_wait", fr + 2, 3 * FRAME);
      wait_idle("p03_idle", 3 * FRAME);
`ifdef UART_TX_PARITY_EN
      check("p07_bits", frame_at(fr), 11'h60E);
      check("p03_bits", frame_at(fr + 1), 11'h406);
`else
      check("p07_bits", frame_at(fr), 11'h20E);
      check("p03_bits", frame_at(fr + 1), 11'h206);
`endif
      check("p07_len", done_at(db) - fall_at(fb), FRAME - 1);
      check("p03_len", done_at(db + 1) - fall_at(fb + 1), FRAME - 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
